// File: rtl/mesi_arb_pkg.sv
// mesi_arb_pkg: FSM state encoding and core ids shared by the two-core MESI request arbiter
package mesi_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_t;
    localparam logic CORE0 = 1'b0;
    localparam logic CORE1 = 1'b1;
endpackage

// File: rtl/mesi_rr_pick.sv
// mesi_rr_pick: combinational two-way round-robin picker; on a tie the core that did not win last goes next
module mesi_rr_pick (
    input  logic [1:0] valids,
    input  logic       last_grant,
    output logic [1:0] grant_onehot,
    output logic       grant_id
);
    import mesi_arb_pkg::*;
    always_comb begin
        grant_id     = (&valids) ? ~last_grant : (valids[1] ? CORE1 : CORE0);
        grant_onehot = (|valids) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    end
endmodule

// File: rtl/mesi_core_arbiter.sv
// mesi_core_arbiter: two-core round-robin front end serializing requests into the MESI cache controller
// Define ARB_TIMEOUT_EN to enable the WAIT watchdog that aborts with rsp_err after TIMEOUT_CYC cycles.
module mesi_core_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core0_valid,
    output logic              core0_ready,
    input  logic [ADDR_W-1:0] core0_addr,
    input  logic              core0_rw,
    input  logic [DATA_W-1:0] core0_wdata,
    input  logic              core1_valid,
    output logic              core1_ready,
    input  logic [ADDR_W-1:0] core1_addr,
    input  logic              core1_rw,
    input  logic [DATA_W-1:0] core1_wdata,
    output logic              cc_valid,
    input  logic              cc_ready,
    output logic              cc_core,
    output logic [ADDR_W-1:0] cc_addr,
    output logic              cc_rw,
    output logic [DATA_W-1:0] cc_wdata,
    input  logic              cc_done,
    input  logic [DATA_W-1:0] cc_rdata,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    import mesi_arb_pkg::*;

    arb_state_t state, next_state;
    logic [1:0] grant_onehot;
    logic       grant_id;
    logic       last_grant;
    logic       cur_core;
    logic       accept;
    logic       wait_exit;
    logic       timed_out;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("mesi_core_arbiter: TIMEOUT_CYC must be in 1..255");
    end

    mesi_rr_pick u_pick (
        .valids       ({core1_valid, core0_valid}),
        .last_grant   (last_grant),
        .grant_onehot (grant_onehot),
        .grant_id     (grant_id)
    );

    assign accept      = (state == IDLE) && (|grant_onehot);
    assign core0_ready = (state == IDLE) && grant_onehot[0];
    assign core1_ready = (state == IDLE) && grant_onehot[1];
    assign cc_core     = cur_core;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Held at zero outside WAIT so every WAIT entry starts counting from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wait_cnt <= '0;
        else        wait_cnt <= (state == WAIT) ? wait_cnt + 8'd1 : 8'd0;
    end

    assign timed_out = (state == WAIT) && !cc_done && (wait_cnt == 8'(TIMEOUT_CYC - 1));
`else
    assign timed_out = 1'b0;
`endif

    assign wait_exit = (state == WAIT) && (cc_done || timed_out);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? ISSUE : IDLE;
            ISSUE:   next_state = cc_ready ? WAIT : ISSUE;
            WAIT:    next_state = wait_exit ? RESP : WAIT;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // cc_addr/cc_rw/cc_wdata double as the request holding registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= CORE1;
            cur_core   <= CORE0;
            cc_valid   <= 1'b0;
            cc_addr    <= '0;
            cc_rw      <= 1'b0;
            cc_wdata   <= '0;
            rsp_valid  <= 2'b00;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state     <= next_state;
            cc_valid  <= (next_state == ISSUE);
            rsp_valid <= (next_state == RESP) ? (cur_core ? 2'b10 : 2'b01) : 2'b00;
            if (accept) begin
                cur_core <= grant_id;
                cc_addr  <= grant_id ? core1_addr : core0_addr;
                cc_rw    <= grant_id ? core1_rw : core0_rw;
                cc_wdata <= grant_id ? core1_wdata : core0_wdata;
            end
            if (wait_exit) begin
                rsp_rdata <= timed_out ? '0 : cc_rdata;
                rsp_err   <= timed_out;
            end
            if (state == RESP) last_grant <= cur_core;
        end
    end
endmodule

// File: tb/tb_mesi_core_arbiter.sv
// tb_mesi_core_arbiter: self-checking bench for mesi_core_arbiter (vector table, corner sequences, randomized model)
module tb_mesi_core_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TCYC = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          core0_valid = 1'b0, core1_valid = 1'b0;
    logic          core0_ready, core1_ready;
    logic [AW-1:0] core0_addr = '0, core1_addr = '0;
    logic          core0_rw = 1'b0, core1_rw = 1'b0;
    logic [DW-1:0] core0_wdata = '0, core1_wdata = '0;
    logic          cc_valid, cc_core, cc_rw;
    logic          cc_ready = 1'b0, cc_done = 1'b0;
    logic [AW-1:0] cc_addr;
    logic [DW-1:0] cc_wdata, rsp_rdata;
    logic [DW-1:0] cc_rdata = '0;
    logic [1:0]    rsp_valid;
    logic          rsp_err;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        logic [1:0]  v;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        rw;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  exp_rdy;
    } vec_t;
    vec_t vt[8];

    mesi_core_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TCYC)) dut (
        .clk(clk), .reset(reset),
        .core0_valid(core0_valid), .core0_ready(core0_ready), .core0_addr(core0_addr),
        .core0_rw(core0_rw), .core0_wdata(core0_wdata),
        .core1_valid(core1_valid), .core1_ready(core1_ready), .core1_addr(core1_addr),
        .core1_rw(core1_rw), .core1_wdata(core1_wdata),
        .cc_valid(cc_valid), .cc_ready(cc_ready), .cc_core(cc_core), .cc_addr(cc_addr),
        .cc_rw(cc_rw), .cc_wdata(cc_wdata), .cc_done(cc_done), .cc_rdata(cc_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " cc_valid"}, 64'(cc_valid), 0);
        chk({tag, " cc_core_addr"}, 64'({cc_core, cc_addr}), 0);
        chk({tag, " cc_rw_wdata"}, 64'({cc_rw, cc_wdata}), 0);
        chk({tag, " rsp_valid"}, 64'(rsp_valid), 0);
        chk({tag, " rsp_err_rdata"}, 64'({rsp_err, rsp_rdata}), 0);
    endtask

    task automatic do_reset();
        core0_valid = 1'b0;
        core1_valid = 1'b0;
        cc_ready = 1'b0;
        cc_done = 1'b0;
        #1 reset = 1'b0;
        step();
        step();
        #2 reset = 1'b1;
        step();
    endtask

    // One transaction with immediate cc_ready and cc_done, starting in IDLE with valids already driven.
    task automatic txn(input string tag, input logic [1:0] er, input logic [31:0] ea, input logic erw,
                       input logic [31:0] ewd, input logic [31:0] rd, input logic [1:0] hold);
        #1 chk({tag, " ready"}, 64'({core1_ready, core0_ready}), 64'(er));
        step();
        {core1_valid, core0_valid} = hold;
        cc_ready = 1'b1;
        #1;
        chk({tag, " cc_valid"}, 64'(cc_valid), 1);
        chk({tag, " cc_core_addr"}, 64'({cc_core, cc_addr}), 64'({er[1], ea}));
        chk({tag, " cc_rw_wdata"}, 64'({cc_rw, cc_wdata}), 64'({erw, ewd}));
        chk({tag, " busy ready"}, 64'({core1_ready, core0_ready}), 0);
        step();
        cc_ready = 1'b0;
        cc_done = 1'b1;
        cc_rdata = rd;
        #1;
        chk({tag, " cc_valid drop"}, 64'(cc_valid), 0);
        chk({tag, " early rsp"}, 64'(rsp_valid), 0);
        step();
        cc_done = 1'b0;
        #1;
        chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(er));
        chk({tag, " rsp_err_rdata"}, 64'({rsp_err, rsp_rdata}), 64'({1'b0, rd}));
        step();
        #1 chk({tag, " rsp_pulse"}, 64'(rsp_valid), 0);
    endtask

    initial begin
        logic [1:0]  pend, er;
        logic [31:0] ra[2], rwd[2];
        logic        rrw[2];
        logic        busy, issue, rsp_due, last_g, tcore, trw;
        logic [31:0] ta, twd, exp_rd;
        int          wleft;

        vt[0] = '{2'b01, 32'h0000_0040, 32'h9999_0000, 1'b0, 32'h0, 32'hDEAD_BEEF, 2'b01};
        vt[1] = '{2'b11, 32'h0000_0100, 32'h0000_0200, 1'b1, 32'hCAFE_0001, 32'h0, 2'b10};
        vt[2] = '{2'b11, 32'h0000_0104, 32'h0000_0204, 1'b0, 32'h0, 32'h0BAD_F00D, 2'b01};
        vt[3] = '{2'b10, 32'h0000_0108, 32'h0000_0208, 1'b0, 32'h0, 32'h1122_3344, 2'b10};
        vt[4] = '{2'b10, 32'h0000_010C, 32'h0000_020C, 1'b1, 32'h55AA_55AA, 32'h0, 2'b10};
        vt[5] = '{2'b11, 32'h0000_0110, 32'h0000_0210, 1'b0, 32'h0, 32'h8765_4321, 2'b01};
        vt[6] = '{2'b01, 32'h0000_0114, 32'h0000_0214, 1'b1, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 2'b01};
        vt[7] = '{2'b11, 32'h0000_0118, 32'h0000_0218, 1'b0, 32'h0, 32'h1357_9BDF, 2'b10};

        step();
        chk_reset_outs("por");
        #2 reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            {core1_valid, core0_valid} = vt[i].v;
            core0_addr = vt[i].a0;
            core1_addr = vt[i].a1;
            core0_rw = vt[i].rw;
            core1_rw = vt[i].rw;
            core0_wdata = vt[i].wd;
            core1_wdata = vt[i].wd;
            txn($sformatf("tbl%0d", i), vt[i].exp_rdy, vt[i].exp_rdy[1] ? vt[i].a1 : vt[i].a0,
                vt[i].rw, vt[i].wd, vt[i].rd, vt[i].v & ~vt[i].exp_rdy);
            {core1_valid, core0_valid} = 2'b00;
        end

        do_reset();
        core0_addr = 32'h300;
        core1_addr = 32'h400;
        core0_rw = 1'b0;
        core1_rw = 1'b0;
        core0_wdata = '0;
        core1_wdata = '0;
        {core1_valid, core0_valid} = 2'b11;
        for (int i = 0; i < 4; i++)
            txn($sformatf("tie%0d", i), i[0] ? 2'b10 : 2'b01, i[0] ? 32'h400 : 32'h300, 1'b0, 32'h0,
                32'hA0 + 32'(i), 2'b11);
        {core1_valid, core0_valid} = 2'b00;

        // cc_ready stall with the other core waiting
        core1_valid = 1'b1;
        core1_addr = 32'h80;
        core1_rw = 1'b1;
        core1_wdata = 32'h1234_5678;
        #1 chk("stall ready", 64'({core1_ready, core0_ready}), 64'(2'b10));
        step();
        core1_valid = 1'b0;
        core0_valid = 1'b1;
        core0_addr = 32'hFFF0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall cc_valid", 64'(cc_valid), 1);
            chk("stall cc_core_addr", 64'({cc_core, cc_addr}), 64'({1'b1, 32'h80}));
            chk("stall cc_rw_wdata", 64'({cc_rw, cc_wdata}), 64'({1'b1, 32'h1234_5678}));
            chk("stall ready", 64'({core1_ready, core0_ready}), 0);
            step();
        end
        core0_valid = 1'b0;
        cc_ready = 1'b1;
        #1 chk("stall cc_valid end", 64'(cc_valid), 1);
        step();
        cc_ready = 1'b0;
        cc_done = 1'b1;
        cc_rdata = '0;
        step();
        cc_done = 1'b0;
        #1 chk("stall rsp", 64'({rsp_valid, rsp_err}), 64'({2'b10, 1'b0}));
        step();

        // cc_done during ISSUE must be ignored
        core0_valid = 1'b1;
        core0_addr = 32'h500;
        core0_rw = 1'b0;
        #1 chk("issdone ready", 64'({core1_ready, core0_ready}), 64'(2'b01));
        step();
        core0_valid = 1'b0;
        cc_done = 1'b1;
        cc_rdata = 32'h1111_1111;
        #1 chk("issdone cc_valid", 64'(cc_valid), 1);
        step();
        cc_done = 1'b0;
        cc_ready = 1'b1;
        #1 chk("issdone no rsp a", 64'({cc_valid, rsp_valid}), 64'({1'b1, 2'b00}));
        step();
        cc_ready = 1'b0;
        cc_done = 1'b1;
        cc_rdata = 32'hA5A5_A5A5;
        #1 chk("issdone no rsp b", 64'({cc_valid, rsp_valid}), 0);
        step();
        cc_done = 1'b0;
        #1 chk("issdone rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({2'b01, 1'b0, 32'hA5A5_A5A5}));
        step();
        #1 chk("issdone single a", 64'(rsp_valid), 0);
        step();
        #1 chk("issdone single b", 64'(rsp_valid), 0);

        // asynchronous reset while waiting for the controller
        core1_valid = 1'b1;
        core1_addr = 32'h600;
        core1_rw = 1'b1;
        core1_wdata = 32'h77;
        #1 chk("rstw ready", 64'({core1_ready, core0_ready}), 64'(2'b10));
        step();
        core1_valid = 1'b0;
        cc_ready = 1'b1;
        #1 chk("rstw cc_core_addr", 64'({cc_core, cc_addr}), 64'({1'b1, 32'h600}));
        step();
        cc_ready = 1'b0;
        #2 reset = 1'b0;
        #1 chk_reset_outs("rstw async");
        @(posedge clk);
        #3 reset = 1'b1;
        step();
        cc_done = 1'b1;
        cc_rdata = 32'hBAD0_0BAD;
        step();
        cc_done = 1'b0;
        #1 chk("rstw late done a", 64'(rsp_valid), 0);
        step();
        #1 chk("rstw late done b", 64'({cc_valid, rsp_valid}), 0);
        {core1_valid, core0_valid} = 2'b11;
        #1 chk("rstw tie", 64'({core1_ready, core0_ready}), 64'(2'b01));
        {core1_valid, core0_valid} = 2'b00;
        step();

        // WAIT behaviour without cc_done
        core0_valid = 1'b1;
        core0_addr = 32'h700;
        #1 chk("wd ready", 64'({core1_ready, core0_ready}), 64'(2'b01));
        step();
        core0_valid = 1'b0;
        cc_ready = 1'b1;
        step();
        cc_ready = 1'b0;
        cc_rdata = 32'hFEED_FACE;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < TCYC; k++) begin
            #1 chk("wd before timeout", 64'(rsp_valid), 0);
            step();
        end
        #1 chk("wd timeout rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({2'b01, 1'b1, 32'h0}));
        step();
        cc_done = 1'b1;
        step();
        cc_done = 1'b0;
        #1 chk("wd late done", 64'(rsp_valid), 0);
`else
        for (int k = 0; k < 20; k++) begin
            #1 chk("wd no timeout", 64'(rsp_valid), 0);
            step();
        end
        cc_done = 1'b1;
        step();
        cc_done = 1'b0;
        #1 chk("wd rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({2'b01, 1'b0, 32'hFEED_FACE}));
`endif
        step();

        // randomized traffic against a transaction-level model
        do_reset();
        pend = 2'b00;
        busy = 1'b0;
        issue = 1'b0;
        rsp_due = 1'b0;
        last_g = 1'b1;
        wleft = -1;
        tcore = 1'b0;
        ta = '0;
        trw = 1'b0;
        twd = '0;
        exp_rd = '0;
        for (int i = 0; i < 2; i++) begin
            ra[i] = '0;
            rrw[i] = 1'b0;
            rwd[i] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    ra[i] = $urandom;
                    rrw[i] = 1'($urandom_range(0, 1));
                    rwd[i] = $urandom;
                end
            {core1_valid, core0_valid} = pend;
            core0_addr = ra[0];
            core0_rw = rrw[0];
            core0_wdata = rwd[0];
            core1_addr = ra[1];
            core1_rw = rrw[1];
            core1_wdata = rwd[1];
            cc_ready = 1'($urandom_range(0, 1));
            cc_rdata = $urandom;
            cc_done = 1'b0;
            if (issue) cc_done = ($urandom_range(0, 3) == 0);
            else if (wleft == 0) begin
                cc_done = 1'b1;
                exp_rd = cc_rdata;
            end
            #1;
            er = busy ? 2'b00 : (pend == 2'b11 ? (last_g ? 2'b01 : 2'b10) : pend);
            chk("rnd ready", 64'({core1_ready, core0_ready}), 64'(er));
            chk("rnd cc_valid", 64'(cc_valid), 64'(issue));
            if (issue) begin
                chk("rnd cc_core_addr", 64'({cc_core, cc_addr}), 64'({tcore, ta}));
                chk("rnd cc_rw_wdata", 64'({cc_rw, cc_wdata}), 64'({trw, twd}));
            end
            chk("rnd rsp_valid", 64'(rsp_valid), rsp_due ? (tcore ? 64'd2 : 64'd1) : 64'd0);
            if (rsp_due) chk("rnd rsp_err_rdata", 64'({rsp_err, rsp_rdata}), 64'({1'b0, exp_rd}));
            if (rsp_due) begin
                rsp_due = 1'b0;
                busy = 1'b0;
                last_g = tcore;
            end else if (wleft == 0) begin
                wleft = -1;
                rsp_due = 1'b1;
            end else if (wleft > 0) wleft--;
            else if (issue && cc_ready) begin
                issue = 1'b0;
                wleft = $urandom_range(0, 3);
            end
            if (er != 2'b00) begin
                tcore = er[1];
                ta = ra[tcore];
                trw = rrw[tcore];
                twd = rwd[tcore];
                pend[tcore] = 1'b0;
                busy = 1'b1;
                issue = 1'b1;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mesi_core_arbiter.md
# mesi_core_arbiter

Two-core request arbiter in front of the MESI cache controller. Each core presents a valid/ready request channel. The arbiter grants one core at a time with round-robin fairness and issues the captured request to the cache controller. It waits for completion and returns the read data to the granted core. Exactly one transaction is outstanding at a time, which serializes coherence actions between the cores.

## Interface
- ADDR_W, 32, request address width
- DATA_W, 32, read/write data width
- TIMEOUT_CYC, 255, watchdog limit in WAIT (used only with ARB_TIMEOUT_EN); range 1..255
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (low = reset)
- core0_valid / core1_valid  in  1  core request pending
- core0_ready / core1_ready  out  1  request accepted this cycle when paired with valid
- core0_addr / core1_addr  in  ADDR_W  request byte address
- core0_rw / core1_rw  in  1  1 = write, 0 = read
- core0_wdata / core1_wdata  in  DATA_W  write data
- cc_valid  out  1  request to cache controller
- cc_ready  in  1  controller accepts request
- cc_core  out  1  granted core id
- cc_addr  out  ADDR_W  captured address
- cc_rw  out  1  captured rw
- cc_wdata  out  DATA_W  captured write data
- cc_done  in  1  one-cycle completion pulse from controller
- cc_rdata  in  DATA_W  read data, valid with cc_done
- rsp_valid  out  2  one-hot per-core response pulse
- rsp_rdata  out  DATA_W  response data
- rsp_err  out  1  response is a timeout abort

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE
  - coreN_ready is combinational and asserted only for the winning core with valid high.
  - A single requester always wins.
  - When both cores request, the core that is not last_grant wins.
  - On valid&ready, the arbiter captures addr, rw and wdata into holding registers, sets cur_core and moves to ISSUE.
- ISSUE
  - cc_valid=1, and cc_core/addr/rw/wdata are held stable from the holding registers.
  - On cc_ready, move to WAIT.
  - cc_done is ignored in ISSUE.
- WAIT
  - On cc_done, capture cc_rdata (0 for writes is acceptable; passed through as-is) and move to RESP.
- RESP
  - rsp_valid[cur_core]=1 for exactly one cycle, with rsp_rdata and rsp_err driven.
  - last_grant is set to cur_core, then the FSM returns to IDLE.
- No core ready is asserted outside IDLE; new requests wait with valid held.
- Reset values:
  - state IDLE, last_grant=1 (so core0 wins the first tie).
  - Holding registers 0; cc_valid 0, cc_core 0, cc_addr 0, cc_rw 0, cc_wdata 0.
  - rsp_valid 2'b00, rsp_rdata 0, rsp_err 0; core ready outputs 0 except the IDLE decode.
- Reset asserted mid-transaction aborts immediately. No response is issued, and a later cc_done is ignored because the FSM is in IDLE.

## Timing
- Accept at cycle T (IDLE), cc_valid at T+1.
- If cc_ready at T+1 and cc_done at T+2: rsp_valid at T+3, IDLE at T+4.
- Minimum spacing between accepts is 4 cycles.
- Each cc_ready stall adds one cycle per cycle of stall, and each cycle of cc_done delay adds one cycle.
- All cc_* and rsp_* outputs are registered; only core ready outputs are combinational from state and valids.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count equals TIMEOUT_CYC without cc_done, go to RESP with rsp_err=1 and rsp_rdata=0.
  - cc_done in the same cycle as the timeout wins, with rsp_err=0.
- ARB_TIMEOUT_EN undefined: no counter, rsp_err tied 0, and WAIT waits indefinitely.

## Structure
- Package mesi_arb_pkg holds:
  - arb_state_t enum (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11).
  - Constants CORE0=1'b0 and CORE1=1'b1.
- Sub-module mesi_rr_pick: combinational 2-way round-robin picker.
  - Inputs: valids[1:0], last_grant.
  - Outputs: grant_onehot[1:0], grant_id.

## Test plan
- Core0 read of 0x0000_0040, cc_ready immediate, cc_done next cycle with 0xDEADBEEF: expect cc_core=0, cc_addr=0x40, cc_rw=0, then rsp_valid=2'b01 with rsp_rdata=0xDEADBEEF at T+3.
- Both cores hold valid continuously from reset for 4 transactions: grant order is 0,1,0,1.
- Core1 write of 0x1234_5678 to 0x80, cc_ready held low for 5 cycles: cc_valid and all cc_* fields stay constant, and neither core ready asserts.
- cc_done pulsed during ISSUE, then cc_ready and a real cc_done with 0xA5A5A5A5: only one rsp_valid, carrying 0xA5A5A5A5.
- Reset driven low in WAIT: all outputs return to reset values asynchronously; a cc_done after reset release produces no rsp_valid, and the next tie grants core0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC=8, no cc_done: rsp_valid with rsp_err=1 and rsp_rdata=0, 8 cycles after WAIT entry; a late cc_done is ignored.
